// File: rtl/scroll_if.sv
`default_nettype none
// ============================================================================
// Module  : scroll_if
// Brief   : Button/strobe inputs and shift-register controls of the scroll
//           controller, grouped as one bundle.
// Revision: 1.0 - initial release
// ============================================================================
interface scroll_if #(
    parameter int DIGITS = 5
);
    localparam int OFF_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic             num_valid;
    logic             btn_left;
    logic             btn_right;
    logic             load;
    logic             en;
    logic             dir;
    logic [OFF_W-1:0] offset;

    modport master (
        output num_valid, btn_left, btn_right,
        input  load, en, dir, offset
    );

    modport slave (
        input  num_valid, btn_left, btn_right,
        output load, en, dir, offset
    );
endinterface
`default_nettype wire

// File: rtl/scroll_controller.sv
`default_nettype none
// ============================================================================
// Module  : scroll_controller
// Brief   : Turns scroll buttons and the new-number strobe into load/en/dir
//           controls for the nibble-rotating register; tracks rotation offset.
// Revision: 1.0 - initial release
// ============================================================================
module scroll_controller #(
    parameter int DIGITS       = 5,
    parameter int REPEAT_DELAY = 25_000_000,
    parameter int REPEAT_RATE  = 5_000_000
) (
    input  logic     clk,
    input  logic     rst,
    scroll_if.slave  bus
);
    localparam int OFF_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] c_DELAY_LD = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] c_RATE_LD  = CNT_W'(REPEAT_RATE - 1);
    localparam logic [OFF_W-1:0] c_OFF_MAX  = OFF_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DELAY  = 2'd1,
        S_REPEAT = 2'd2
    } state_t;

    logic             r_sl_meta, r_sl, r_sr_meta, r_sr;
    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_btn_right, w_btn_right_nxt;
    logic             r_load, r_en, r_dir;
    logic [OFF_W-1:0] r_offset;

    logic             w_valid;
    logic             w_shift;

    assign w_valid = r_sl ^ r_sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sl_meta <= 1'b0;
            r_sl      <= 1'b0;
            r_sr_meta <= 1'b0;
            r_sr      <= 1'b0;
        end else begin
            r_sl_meta <= bus.btn_left;
            r_sl      <= r_sl_meta;
            r_sr_meta <= bus.btn_right;
            r_sr      <= r_sr_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_btn_right <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_btn_right <= w_btn_right_nxt;
        end
    end

    // A different valid press while holding is a release; the new press is
    // picked up from IDLE on the next cycle.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_btn_right_nxt = r_btn_right;
        w_shift         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_valid) begin
                    w_shift         = 1'b1;
                    w_btn_right_nxt = r_sr;
                    w_cnt_nxt       = c_DELAY_LD;
                    w_state_nxt     = S_DELAY;
                end
            end
            S_DELAY, S_REPEAT: begin
                if (!w_valid || (r_sr != r_btn_right)) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == '0) begin
                    w_shift     = 1'b1;
                    w_cnt_nxt   = c_RATE_LD;
                    w_state_nxt = S_REPEAT;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
        // A load overrides everything, so a held button re-presses afterwards.
        if (bus.num_valid) begin
            w_shift     = 1'b0;
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_load   <= 1'b0;
            r_en     <= 1'b0;
            r_dir    <= 1'b0;
            r_offset <= '0;
        end else begin
            r_load <= bus.num_valid;
            r_en   <= w_shift;
            if (w_shift) begin
                r_dir <= r_btn_right_eff();
            end
            if (bus.num_valid) begin
                r_offset <= '0;
            end else if (w_shift) begin
                if (r_btn_right_eff()) begin
                    r_offset <= (r_offset == '0) ? c_OFF_MAX : r_offset - OFF_W'(1);
                end else begin
                    r_offset <= (r_offset == c_OFF_MAX) ? '0 : r_offset + OFF_W'(1);
                end
            end
        end
    end

    // Direction of the shift being issued this cycle.
    function automatic logic r_btn_right_eff();
        return w_btn_right_nxt;
    endfunction

    assign bus.load   = r_load;
    assign bus.en     = r_en;
    assign bus.dir    = r_dir;
    assign bus.offset = r_offset;

endmodule
`default_nettype wire

// File: tb/tb_scroll_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_scroll_controller
// Brief   : Self-checking bench for scroll_controller with a hold-time model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_scroll_controller;
    localparam int DIGITS = 5;
    localparam int RD     = 8;
    localparam int RR     = 4;

    logic clk    = 1'b0;
    logic clk_en = 1'b1;
    logic rst    = 1'b1;

    int vectors    = 0;
    int miscompares = 0;

    scroll_if #(.DIGITS(DIGITS)) bus ();

    scroll_controller #(
        .DIGITS      (DIGITS),
        .REPEAT_DELAY(RD),
        .REPEAT_RATE (RR)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 if (clk_en) clk = ~clk;

    // Reference: the shift schedule is a function of how long the same single
    // button has been continuously seen (age) after the two-cycle sync delay.
    logic s1l, s2l, s1r, s2r;
    int   age;
    logic held;
    logic m_load, m_en, m_dir;
    int   m_off;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            s1l = 0; s2l = 0; s1r = 0; s2r = 0;
            age = 0; held = 0;
            m_load = 0; m_en = 0; m_dir = 0; m_off = 0;
        end else begin
            logic pl, pr, shift;
            pl = s2l & ~s2r;
            pr = s2r & ~s2l;
            shift = 0;
            m_load = bus.num_valid;
            if (bus.num_valid) begin
                age = 0;
                m_off = 0;
            end else if (!(pl | pr)) begin
                age = 0;
            end else if (age == 0) begin
                age = 1;
                held = pr;
            end else if (pr != held) begin
                age = 0;
            end else begin
                age++;
            end
            if (!bus.num_valid && age > 0)
                shift = (age == 1) || (age > RD && ((age - 1 - RD) % RR) == 0);
            m_en = shift;
            if (shift) begin
                m_dir = held;
                m_off = (m_off + (held ? DIGITS - 1 : 1)) % DIGITS;
            end
            s2l = s1l; s1l = bus.btn_left;
            s2r = s1r; s1r = bus.btn_right;
        end
    end

    task automatic test_reset();
        bus.num_valid = 0; bus.btn_left = 0; bus.btn_right = 0;
        rst = 1;
        repeat (3) @(negedge clk);
        rst = 0;
        bus.btn_right = 1;
        repeat (4) @(negedge clk);
        bus.btn_right = 0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({bus.dir, bus.offset} !== 4'b1100) begin
            miscompares++;
            $display("FAIL pre_reset_state got dir/off=%b/%0d want 1/4", bus.dir, bus.offset);
        end
        clk_en = 0;
        #2 rst = 1;
        #1;
        vectors++;
        if ({bus.load, bus.en, bus.dir, bus.offset} !== 6'b0) begin
            miscompares++;
            $display("FAIL async_reset got l/e/d/o=%b%b%b%0d want 0000", bus.load, bus.en, bus.dir, bus.offset);
        end
        #5 clk_en = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vectors++;
            if ({bus.load, bus.en, bus.offset} !== 5'b0) begin
                miscompares++;
                $display("FAIL reset_idle cyc %0d got l/e/o=%b%b%0d want 000", i, bus.load, bus.en, bus.offset);
            end
        end
    endtask

    task automatic test_left_tap();
        int pulses = 0;
        bus.btn_left = 1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            vectors++;
            if ({bus.load, bus.en, bus.dir, bus.offset} !== {m_load, m_en, m_dir, 3'(m_off)}) begin
                miscompares++;
                $display("FAIL tap_model cyc %0d got %b%b%b%0d want %b%b%b%0d", i, bus.load, bus.en, bus.dir, bus.offset, m_load, m_en, m_dir, m_off);
            end
            if (bus.en) pulses++;
            if (i == 3) begin
                vectors++;
                if ({bus.en, bus.dir, bus.offset} !== 5'b10001) begin
                    miscompares++;
                    $display("FAIL tap_pulse got e/d/o=%b%b%0d want 1/0/1", bus.en, bus.dir, bus.offset);
                end
                bus.btn_left = 0;
            end
        end
        vectors++;
        if (pulses !== 1) begin
            miscompares++;
            $display("FAIL tap_count got %0d want 1", pulses);
        end
    endtask

    task automatic test_hold_right();
        int exp_pos [4] = '{3, 11, 15, 19};
        int exp_off [4] = '{4, 3, 2, 1};
        int np = 0;
        bus.num_valid = 1;
        @(negedge clk);
        bus.num_valid = 0;
        vectors++;
        if ({bus.load, bus.en, bus.offset} !== 5'b10000) begin
            miscompares++;
            $display("FAIL load_clear got l/e/o=%b%b%0d want 1/0/0", bus.load, bus.en, bus.offset);
        end
        bus.btn_right = 1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            vectors++;
            if ({bus.load, bus.en, bus.dir, bus.offset} !== {m_load, m_en, m_dir, 3'(m_off)}) begin
                miscompares++;
                $display("FAIL hold_model cyc %0d got %b%b%b%0d want %b%b%b%0d", i, bus.load, bus.en, bus.dir, bus.offset, m_load, m_en, m_dir, m_off);
            end
            if (bus.en) begin
                vectors++;
                if (np >= 4 || i != exp_pos[np] || bus.dir !== 1'b1 || bus.offset !== 3'(exp_off[np])) begin
                    miscompares++;
                    $display("FAIL hold_pulse #%0d at cyc %0d dir=%b off=%0d want cyc %0d dir 1 off %0d",
                             np, i, bus.dir, bus.offset, (np < 4) ? exp_pos[np] : -1, (np < 4) ? exp_off[np] : -1);
                end
                np++;
            end
            if (i == 20) bus.btn_right = 0;
        end
        vectors++;
        if (np !== 4) begin
            miscompares++;
            $display("FAIL hold_count got %0d want 4", np);
        end
    endtask

    task automatic test_wrap_left();
        bus.num_valid = 1;
        @(negedge clk);
        bus.num_valid = 0;
        for (int k = 1; k <= 5; k++) begin
            bus.btn_left = 1;
            for (int i = 1; i <= 11; i++) begin
                @(negedge clk);
                vectors++;
                if ({bus.load, bus.en, bus.dir, bus.offset} !== {m_load, m_en, m_dir, 3'(m_off)}) begin
                    miscompares++;
                    $display("FAIL wrap_model tap %0d cyc %0d got %b%b%b%0d want %b%b%b%0d", k, i, bus.load, bus.en, bus.dir, bus.offset, m_load, m_en, m_dir, m_off);
                end
                if (i == 3) bus.btn_left = 0;
            end
            vectors++;
            if (bus.offset !== 3'(k % DIGITS)) begin
                miscompares++;
                $display("FAIL wrap_offset tap %0d got %0d want %0d", k, bus.offset, k % DIGITS);
            end
        end
    endtask

    task automatic test_both_swap();
        int pulses = 0;
        bus.btn_left = 1; bus.btn_right = 1;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            if (bus.en) pulses++;
        end
        vectors++;
        if (pulses !== 0) begin
            miscompares++;
            $display("FAIL both_no_shift got %0d pulses want 0", pulses);
        end
        bus.btn_right = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 3) begin
                vectors++;
                if ({bus.en, bus.dir} !== 2'b10) begin
                    miscompares++;
                    $display("FAIL both_drop_left got e/d=%b%b want 10", bus.en, bus.dir);
                end
            end
        end
        bus.btn_left = 0; bus.btn_right = 1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            vectors++;
            if ({bus.load, bus.en, bus.dir, bus.offset} !== {m_load, m_en, m_dir, 3'(m_off)}) begin
                miscompares++;
                $display("FAIL swap_model cyc %0d got %b%b%b%0d want %b%b%b%0d", i, bus.load, bus.en, bus.dir, bus.offset, m_load, m_en, m_dir, m_off);
            end
            if (i == 3 && bus.en !== 1'b0) begin
                miscompares++;
                $display("FAIL swap_abort got en=%b want 0", bus.en);
            end
            if (i == 4 && {bus.en, bus.dir} !== 2'b11) begin
                miscompares++;
                $display("FAIL swap_right got e/d=%b%b want 11", bus.en, bus.dir);
            end
        end
        bus.btn_right = 0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_collision();
        bus.num_valid = 1;
        @(negedge clk);
        bus.num_valid = 0;
        bus.btn_left = 1;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            vectors++;
            if ({bus.load, bus.en, bus.dir, bus.offset} !== {m_load, m_en, m_dir, 3'(m_off)}) begin
                miscompares++;
                $display("FAIL coll_model cyc %0d got %b%b%b%0d want %b%b%b%0d", i, bus.load, bus.en, bus.dir, bus.offset, m_load, m_en, m_dir, m_off);
            end
            if (i == 10) bus.num_valid = 1;
            if (i == 11) begin
                bus.num_valid = 0;
                vectors++;
                if ({bus.load, bus.en, bus.offset} !== 5'b10000) begin
                    miscompares++;
                    $display("FAIL coll_load got l/e/o=%b%b%0d want 1/0/0", bus.load, bus.en, bus.offset);
                end
            end
            if (i == 12) begin
                vectors++;
                if ({bus.load, bus.en, bus.dir, bus.offset} !== 6'b010001) begin
                    miscompares++;
                    $display("FAIL coll_reshift got l/e/d/o=%b%b%b%0d want 0/1/0/1", bus.load, bus.en, bus.dir, bus.offset);
                end
            end
        end
        bus.btn_left = 0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_random();
        int cyc = 0;
        while (cyc < 2000) begin
            logic [1:0] pat;
            int len;
            pat = 2'($urandom_range(0, 3));
            len = $urandom_range(1, 24);
            bus.btn_left  = pat[0];
            bus.btn_right = pat[1];
            for (int j = 0; j < len; j++) begin
                @(negedge clk);
                cyc++;
                vectors++;
                if ({bus.load, bus.en, bus.dir, bus.offset} !== {m_load, m_en, m_dir, 3'(m_off)} ||
                    (bus.load & bus.en)) begin
                    miscompares++;
                    $display("FAIL rand_model cyc %0d got %b%b%b%0d want %b%b%b%0d", cyc, bus.load, bus.en, bus.dir, bus.offset, m_load, m_en, m_dir, m_off);
                end
                bus.num_valid = ($urandom_range(0, 29) == 0);
            end
        end
        bus.num_valid = 0; bus.btn_left = 0; bus.btn_right = 0;
    endtask

    initial begin
        test_reset();
        test_left_tap();
        test_hold_right();
        test_wrap_left();
        test_both_swap();
        test_collision();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
